// File: rtl/mips_isa_pkg.sv
// MIPS subset shared by the program loader and the CPU control logic:
// loader request kinds, primary opcodes and R-type function codes.
package mips_isa_pkg;

    localparam logic [3:0] KIND_ADD  = 4'd0;
    localparam logic [3:0] KIND_SUB  = 4'd1;
    localparam logic [3:0] KIND_AND  = 4'd2;
    localparam logic [3:0] KIND_OR   = 4'd3;
    localparam logic [3:0] KIND_SLT  = 4'd4;
    localparam logic [3:0] KIND_ADDI = 4'd5;
    localparam logic [3:0] KIND_ANDI = 4'd6;
    localparam logic [3:0] KIND_ORI  = 4'd7;
    localparam logic [3:0] KIND_SLTI = 4'd8;
    localparam logic [3:0] KIND_SW   = 4'd9;
    localparam logic [3:0] KIND_LW   = 4'd10;
    localparam logic [3:0] KIND_J    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: request kind plus fields -> 32-bit MIPS word.
// Kind 11 (J) is legal only when IMEM_LOADER_JUMP_EN is defined.
module mips_instr_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_ADD:  word = r_word(rs, rt, rd, FN_ADD);
            KIND_SUB:  word = r_word(rs, rt, rd, FN_SUB);
            KIND_AND:  word = r_word(rs, rt, rd, FN_AND);
            KIND_OR:   word = r_word(rs, rt, rd, FN_OR);
            KIND_SLT:  word = r_word(rs, rt, rd, FN_SLT);
            KIND_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
            KIND_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
            KIND_ORI:  word = i_word(OP_ORI, rs, rt, imm);
            KIND_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
            KIND_SW:   word = i_word(OP_SW, rs, rt, imm);
            KIND_LW:   word = i_word(OP_LW, rs, rt, imm);
`ifdef IMEM_LOADER_JUMP_EN
            // 26-bit jump target is simply rs:rt:imm packed together
            KIND_J:    word = {OP_J, rs, rt, imm};
`endif
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Encodes symbolic instruction requests and writes them sequentially into
// instruction memory, holding the CPU until the load completes.
// Optional jump support: define IMEM_LOADER_JUMP_EN.
//
// state   | meaning
// S_IDLE  | ready for the next request
// S_WRITE | one-cycle memory write of the accepted word
// S_DONE  | program loaded, CPU released (sticky)
// S_ERR   | illegal kind or memory full without last (sticky)
module imem_program_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_ERR} state_e;

    state_e          state;
    state_e          state_nxt;
    logic [ADDR_W:0] cnt;
    logic            last_q;
    logic [31:0]     enc_word;
    logic            enc_illegal;
    logic            accept;

    mips_instr_encode u_encode (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = enc_illegal ? S_ERR : S_WRITE;
            S_WRITE: begin
                if (last_q)               state_nxt = S_DONE;
                else if (cnt == CNT_LAST) state_nxt = S_ERR;
                else                      state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state == S_WRITE);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        cpu_hold = (state != S_DONE);
    end

    // Write strobe, address and data are loaded on the accepting edge so they
    // line up exactly with the WRITE state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            last_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            imem_we <= accept && !enc_illegal;
            if (accept && !enc_illegal) begin
                imem_addr  <= cnt[ADDR_W-1:0];
                imem_wdata <= enc_word;
                last_q     <= in_last;
            end
            if (state == S_WRITE) cnt <= cnt + 1'b1;
        end
    end

    assign word_count = cnt;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader (small memory, ADDR_W=2):
// directed test-plan cases plus randomized request streams vs a reference model.
module tb_imem_program_loader;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_kind = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rd = '0;
    logic [15:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    imem_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: words written, load finished, load failed
    int m_count;
    bit m_done;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // {legal, word} straight from the instruction table
    function automatic logic [32:0] ref_enc(input logic [3:0] k, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm);
        case (k)
            4'd0:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd3:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd4:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd5:  return {1'b1, 6'h08, rs, rt, imm};
            4'd6:  return {1'b1, 6'h0C, rs, rt, imm};
            4'd7:  return {1'b1, 6'h0D, rs, rt, imm};
            4'd8:  return {1'b1, 6'h0A, rs, rt, imm};
            4'd9:  return {1'b1, 6'h2B, rs, rt, imm};
            4'd10: return {1'b1, 6'h23, rs, rt, imm};
`ifdef IMEM_LOADER_JUMP_EN
            4'd11: return {1'b1, 6'h02, rs, rt, imm};
`endif
            default: return 33'd0;
        endcase
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", word_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_ready", in_ready, 1);
        rst_n   = 1'b1;
        m_count = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge so requests can go back to back.
    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last,
                        input bit hold);
        logic [32:0] r;
        bit idle;
        r    = ref_enc(k, rs, rt, rd, imm);
        idle = !m_done && !m_err;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        chk("ready", in_ready, 32'(idle));
        if (!idle) begin
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                chk("locked_we", imem_we, 0);
                chk("locked_done", done, 32'(m_done));
                chk("locked_err", err, 32'(m_err));
                chk("locked_hold", cpu_hold, 32'(!m_done));
                chk("locked_count", word_count, m_count);
            end
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!r[32]) begin
            chk("illegal_we", imem_we, 0);
            chk("illegal_err", err, 1);
            chk("illegal_ready", in_ready, 0);
            chk("illegal_hold", cpu_hold, 1);
            in_valid = 1'b0;
            m_err    = 1'b1;
            return;
        end
        chk("wr_we", imem_we, 1);
        chk("wr_addr", imem_addr, m_count % DEPTH);
        chk("wr_data", imem_wdata, r[31:0]);
        chk("wr_busy", busy, 1);
        chk("wr_ready", in_ready, 0);
        if (!hold) in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        m_count++;
        if (last) m_done = 1'b1;
        else if (m_count == DEPTH) m_err = 1'b1;
        chk("post_we", imem_we, 0);
        chk("post_count", word_count, m_count);
        chk("post_done", done, 32'(m_done));
        chk("post_err", err, 32'(m_err));
        chk("post_hold", cpu_hold, 32'(!m_done));
        chk("post_ready", in_ready, 32'(!m_done && !m_err));
        chk("post_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] k;
        @(negedge clk);

        // ADD r3 = r1 + r2, single-word program
        do_reset();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 1'b0);
        chk("add_word", imem_wdata, 32'h00221820);

        // LW then SW, back to back
        do_reset();
        send(4'd10, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b0, 1'b0);
        send(4'd9, 5'd29, 5'd31, 5'd0, 16'hFFFC, 1'b1, 1'b0);
        chk("sw_word", imem_wdata, 32'hAFBFFFFC);

        // illegal kind, then ignored request
        do_reset();
        send(4'd15, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0, 1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 1'b0);

        // fill memory without last -> overflow, fifth request ignored
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            send(4'd7, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3), 1'b0, 1'b0);
        send(4'd7, 5'd9, 5'd9, 5'd0, 16'h9, 1'b0, 1'b0);

        // valid held through WRITE, then reset on an accepting edge
        do_reset();
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0, 1'b1);
        in_kind = 4'd0; in_valid = 1'b1; in_last = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_accept_we", imem_we, 0);
        chk("rst_accept_count", word_count, 0);
        chk("rst_accept_busy", busy, 0);
        in_valid = 1'b0; rst_n = 1'b1;
        m_count = 0; m_done = 1'b0; m_err = 1'b0;
        send(4'd7, 5'd2, 5'd3, 5'd0, 16'h00FF, 1'b1, 1'b0);

        // jump kind: encoded when enabled, illegal otherwise
        do_reset();
        send(4'd11, 5'd0, 5'd0, 5'd0, 16'h0010, 1'b1, 1'b0);

        // randomized request streams
        for (int t = 0; t < 40; t++) begin
            do_reset();
            for (int n = 0; n < 8 && !m_done && !m_err; n++) begin
                if ($urandom_range(0, 9) == 0) k = 4'($urandom_range(11, 15));
                else                           k = 4'($urandom_range(0, 10));
                send(k, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            end
            send(4'($urandom_range(0, 10)), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Encoder-side counterpart to the single-cycle CPU's instruction decode logic.
- Accepts symbolic instruction requests (kind plus register and immediate fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word.
- Writes the encoded words sequentially into instruction memory.
- Holds the CPU off until the program load completes.
- Sits between the testbench/boot source and the instruction memory write port.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  loader can accept a request this cycle.
- in_kind  in  4  instruction kind (see Behaviour).
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  16  immediate field.
- in_last  in  1  marks the final instruction of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction word.
- word_count  out  ADDR_W+1  number of words written so far.
- busy  out  1  a request is being processed.
- done  out  1  program loaded; sticky.
- err  out  1  illegal kind or capacity overflow; sticky.
- cpu_hold  out  1  keep the CPU stalled; 1 unless done.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, pointer=0.
  - imem_we=0, imem_addr=0, imem_wdata=0, word_count=0.
  - busy=0, done=0, err=0, cpu_hold=1.
  - Reset wins over every other event, including mid-WRITE: no write is issued in the cycle after reset is sampled.
- Kinds:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT: R-type. Word = {6'h00, rs, rt, rd, 5'd0, funct}; funct = 20, 22, 24, 25, 2A hex respectively.
  - 5 ADDI, 6 ANDI, 7 ORI, 8 SLTI, 9 SW, 10 LW: I-type. Word = {op, rs, rt, imm}; op = 08, 0C, 0D, 0A, 2B, 23 hex respectively.
  - in_rd is ignored for I-type kinds.
  - Any other kind is illegal.
- FSM states: IDLE, WRITE, DONE, ERR.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register the fields and in_last.
  - Legal kind: go to WRITE.
  - Illegal kind: go to ERR, no write.
- WRITE (exactly one cycle):
  - in_ready=0, busy=1.
  - imem_we=1, imem_addr=pointer, imem_wdata=encoded word. All three are registered outputs.
  - Next edge: pointer++, word_count++.
  - If in_last was set: go to DONE.
  - Else if pointer+1 == DEPTH: go to ERR (overflow).
  - Else: return to IDLE.
- Throughput: one word per 2 cycles. Latency from accept to imem_we: 1 cycle.
- in_valid held high while in_ready=0 is never double-accepted; the source must hold its fields stable until accepted.
- DONE:
  - done=1, cpu_hold=0, in_ready=0.
  - Sticky until reset.
- ERR:
  - err=1, cpu_hold=1, in_ready=0, imem_we=0.
  - Sticky until reset.
- imem_we is 0 in every state except WRITE.

Optional Feature:
- Macro: IMEM_LOADER_JUMP_EN.
- Defined: kind 11 = J, word = {6'h02, rs, rt, imm}. The 26-bit target is the concatenation rs:rt:imm.
- Undefined: kind 11 is illegal and goes to ERR.

Decomposition:
- Package mips_isa_pkg holds:
  - the kind encodings;
  - the opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_SW, OP_LW, OP_J);
  - the funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT).
- The package is shared with the CPU control logic.
- One combinational sub-module, mips_instr_encode: kind/fields in, word plus illegal flag out.
- The FSM, pointer and output registers stay in imem_program_loader.

Test Plan:
- Reset, then ADD rs=1 rt=2 rd=3 last=1 -> one cycle imem_we=1, addr=0, wdata=0x00221820; then done=1, cpu_hold=0, word_count=1.
- LW rs=0 rt=8 imm=0x0004, then SW rs=29 rt=31 imm=0xFFFC last=1 -> writes 0x8C080004 @0 and 0xAFBFFFFC @1; done after the second write; 4 cycles from first accept to done.
- kind=15 -> no imem_we, err=1, in_ready=0, cpu_hold=1; later requests are ignored until rst_n low.
- ADDR_W=2, four ORI requests without last -> writes @0..3, then err=1, word_count=4, no fifth write.
- in_valid held high through WRITE -> exactly one accept per request. rst_n low in the cycle an accept occurs -> no write, pointer=0, word_count=0.
- IMEM_LOADER_JUMP_EN defined, kind=11 rs=0 rt=0 imm=0x0010 -> wdata=0x08000010. Undefined -> err=1, no write.
